// File: rtl/full_adder.sv
// One-bit full adder; the ripple cell of the slt subtractor chain.
// Purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  logic p;

  assign p     = a ^ b;
  assign sum   = p ^ c_in;
  assign c_out = (a & b) | (p & c_in);

endmodule

// File: rtl/slt.sv
// N-bit signed set-less-than built on a ripple a + ~b + 1 chain.
// Also provides a registered copy of the result for pipelined users.
module slt #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out,
  output logic         out_q
);

  logic [N:0]   c;
  logic [N-2:0] d_unused;
  logic         d_msb;
  logic         ovf;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_fa
    if (i == N - 1) begin : g_msb
      full_adder u_fa (
        .a    (a[i]),
        .b    (~b[i]),
        .c_in (c[i]),
        .sum  (d_msb),
        .c_out(c[i+1])
      );
    end else begin : g_lsb
      full_adder u_fa (
        .a    (a[i]),
        .b    (~b[i]),
        .c_in (c[i]),
        .sum  (d_unused[i]),
        .c_out(c[i+1])
      );
    end
  end

  // Sign of the difference is wrong exactly when the subtraction overflows.
  assign ovf = c[N-1] ^ c[N];
  assign out = d_msb ^ ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out;
    end
  end

endmodule

// File: tb/tb_slt.sv
// Directed and random checks of slt at N=32 and N=8.
// Covers overflow corners and the registered output with async reset.
module tb_slt;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        out;
  logic        out_q;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        out8;
  logic        out8_q;

  int tests;
  int fails;

  slt #(.N(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .out  (out),
    .out_q(out_q)
  );

  slt #(.N(8)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a8),
    .b    (b8),
    .out  (out8),
    .out_q(out8_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    a = 32'hFFFF_FFFF;
    b = 32'h0000_0001;
    #1;
    tests++;
    if (out_q !== 1'b0) begin
      fails++;
      $display("FAIL reset_out_q: got %b want 0", out_q);
    end
    @(posedge clk);
    #1;
    tests++;
    if (out_q !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold_out_q: got %b want 0", out_q);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [4] = '{32'd0, 32'd5, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] vb [4] = '{32'd0, 32'd5, 32'd1, 32'hFFFF_FFFF};
    logic        ve [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      a = va[i];
      b = vb[i];
      #1;
      tests++;
      if (out !== ve[i]) begin
        fails++;
        $display("FAIL directed[%0d] a=%h b=%h: got %b want %b",
                 i, a, b, out, ve[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] va [4] = '{32'h7FFF_FFFF, 32'h8000_0000,
                            32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] vb [4] = '{32'h8000_0000, 32'h7FFF_FFFF,
                            32'h8000_0000, 32'h7FFF_FFFF};
    logic        ve [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      a = va[i];
      b = vb[i];
      #1;
      tests++;
      if (out !== ve[i]) begin
        fails++;
        $display("FAIL overflow[%0d] a=%h b=%h: got %b want %b",
                 i, a, b, out, ve[i]);
      end
    end
  endtask

  task automatic test_random();
    logic exp;
    for (int i = 0; i < 100; i++) begin
      a = $random;
      b = $random;
      if (i % 10 == 0) b = a;
      exp = ($signed(a) < $signed(b));
      #1;
      tests++;
      if (out !== exp) begin
        fails++;
        $display("FAIL random[%0d] a=%h b=%h: got %b want %b",
                 i, a, b, out, exp);
      end
    end
  endtask

  task automatic test_registered();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a = 32'hFFFF_FFFF;
    b = 32'h0000_0001;
    @(posedge clk);
    #1;
    tests++;
    if (out_q !== 1'b1) begin
      fails++;
      $display("FAIL reg_capture: got %b want 1", out_q);
    end
    a = 32'd3;
    b = 32'd2;
    @(posedge clk);
    #1;
    tests++;
    if (out_q !== 1'b0) begin
      fails++;
      $display("FAIL reg_follow: got %b want 0", out_q);
    end
    a = 32'h8000_0000;
    b = 32'd0;
    @(posedge clk);
    #1;
    tests++;
    if (out_q !== 1'b1) begin
      fails++;
      $display("FAIL reg_follow2: got %b want 1", out_q);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_q !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got %b want 0", out_q);
    end
    tests++;
    if (out !== 1'b1) begin
      fails++;
      $display("FAIL out_in_reset: got %b want 1", out);
    end
    a = 32'd9;
    b = 32'd4;
    #1;
    tests++;
    if (out !== 1'b0) begin
      fails++;
      $display("FAIL out_track_reset: got %b want 0", out);
    end
  endtask

  task automatic test_n8();
    logic [7:0] va [7] = '{8'h00, 8'h05, 8'hFF, 8'h01, 8'h7F, 8'h80, 8'h80};
    logic [7:0] vb [7] = '{8'h00, 8'h05, 8'h01, 8'hFF, 8'h80, 8'h7F, 8'h80};
    logic       ve [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      a8 = va[i];
      b8 = vb[i];
      #1;
      tests++;
      if (out8 !== ve[i]) begin
        fails++;
        $display("FAIL n8[%0d] a=%h b=%h: got %b want %b",
                 i, a8, b8, out8, ve[i]);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    a = '0;
    b = '0;
    a8 = '0;
    b8 = '0;
    test_reset();
    test_directed();
    test_overflow();
    test_random();
    test_registered();
    test_n8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/slt.md
# slt

Parameterized N-bit signed set-less-than comparator. Drives `out` = 1 when `a < b` as two's-complement integers, computed structurally as `a − b` through a ripple-carry adder with overflow correction. It is the compare leaf of the ALU datapath and also provides a registered copy of the result for pipelined consumers.

## Interface
- `N`, default 32: operand width in bits; legal for N ≥ 2.
- `clk`  input  1: clock; only the registered copy `out_q` uses it.
- `rst_n`  input  1: asynchronous, active-low reset; clears `out_q`.
- `a`  input  N: left operand, signed two's complement.
- `b`  input  N: right operand, signed two's complement.
- `out`  output  1: combinational result, 1 iff `a < b` (signed).
- `out_q`  output  1: `out` registered on the rising edge of `clk`.
- One clock; reset is asynchronous and active-low.

## Operation
- Compute `d = a + ~b + 1` over N bits:
  - carry-in = 1;
  - `c_msb_in` = carry into bit N−1;
  - `c_out` = carry out of bit N−1.
- Overflow: `ovf = c_msb_in ^ c_out`.
- Result: `out = d[N-1] ^ ovf`. Correct for all operand pairs, including the cases where `a − b` overflows.
- `a == b`: `out = 0`.
- The comparison is strictly signed; no unsigned mode.
- Inputs with X/Z bits are not specified. Known 0/1 inputs always produce a known 0/1 `out`, never X.
- `out_q`:
  - `rst_n = 0` forces `out_q = 0` immediately, independent of `clk`.
  - While `rst_n = 1`, `out_q <= out` on each rising edge of `clk`.
  - Reset deassertion takes effect at the next rising edge.

## Timing
- `out` is purely combinational; zero-cycle latency. It must settle within one testbench time step (1 ns) of any input change. It has no dependency on `clk` or `rst_n`.
- `out_q` has 1-cycle latency and reflects the operands present at the preceding rising edge.
- Reset value of `out_q` is 0.
- Asserting reset mid-stream clears `out_q` asynchronously; `out` keeps tracking the inputs.
- Critical path is the N-stage ripple carry; no lookahead is required.

## Structure
- No shared package is needed. N is a module parameter; no typedefs.
- Sub-module `full_adder` (a, b, c_in → sum, c_out), instantiated N times in a generate loop. Operand `b` is fed inverted into each instance.
- Top-level `slt` holds:
  - the generate chain;
  - the overflow XOR and result XOR;
  - the single `always_ff` with async active-low reset for `out_q`.
- No behavioural `<` operator is allowed in the RTL. The comparison must come from the adder chain.

## Test plan
- a=0, b=0 -> out=0. a=5, b=5 -> out=0.
- a=−1, b=1 -> out=1. a=1, b=−1 -> out=0.
- Overflow corners, N=32:
  - a=0x7FFFFFFF, b=0x80000000 -> out=0;
  - a=0x80000000, b=0x7FFFFFFF -> out=1;
  - a=0x80000000, b=0x80000000 -> out=0.
- 100 random $random pairs: `out` must match the signed `a < b` reference 1 ns after each change, with zero mismatches.
- Registered path:
  - hold `rst_n=0` -> `out_q=0`;
  - release reset, apply a=−1, b=1, clock once -> `out_q=1`;
  - drop `rst_n` mid-cycle -> `out_q=0` without a clock edge.
- Re-run the directed cases with N=8, e.g. a=0x7F, b=0x80 -> out=0, to confirm parameterization.
